// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store per valid/ready handshake, fixed LATENCY.
// Optional misalignment/undefined-funct3 error reporting is enabled by defining DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg;
    logic [3:0]         cnt_reg;
    logic               req_ready_reg;
    logic               resp_valid_reg;
    logic               load_ok_reg;
    logic [2:0]         f3_reg;
    logic [1:0]         lane_reg;
    logic [31:0]        rd_word_reg;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               accept;
    logic               size_b;
    logic               size_h;
    logic               size_w;
    logic               f3_undef;
    logic               access_ok;
    logic [3:0]         be;
    logic [3:0]         be_wr;
    logic [31:0]        wlane;
    logic [ADDR_W-1:0]  widx;
    logic               unused_addr_bits;

    assign accept   = req_valid & req_ready_reg;
    assign widx     = req_addr[ADDR_W+1:2];
    assign size_b   = (req_func3[1:0] == 2'b00);
    assign size_h   = (req_func3[1:0] == 2'b01);
    assign size_w   = (req_func3 == 3'b010);
    assign f3_undef = (req_func3 == 3'b011) | (req_func3[2] & req_func3[1]);

    // Upper address bits wrap modulo the array size.
    assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W+2]};

`ifdef DMEM_MISALIGN_ERR_EN
    logic misaligned;
    logic err_reg;

    assign misaligned = (size_h & req_addr[0]) | (size_w & (req_addr[1:0] != 2'b00));
    assign access_ok  = ~f3_undef & ~misaligned;
    assign resp_err   = err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= f3_undef | misaligned;
        end
    end
`else
    assign access_ok = ~f3_undef;
    assign resp_err  = 1'b0;
`endif

    // Byte enables: misaligned H/W are aligned down when errors are not reported.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            assign be[gi] = size_w
                          | (size_h & (req_addr[1] == gi[1]))
                          | (size_b & (req_addr[1:0] == gi[1:0]));
        end
    endgenerate

    assign be_wr = be & {4{access_ok & req_write}};

    always_comb begin
        wlane = req_wdata;
        if (size_b) begin
            wlane = {4{req_wdata[7:0]}};
        end else if (size_h) begin
            wlane = {2{req_wdata[15:0]}};
        end
    end

    // Array port: byte-enable write and registered read, both at the accept edge.
    always_ff @(posedge clk) begin
        if (accept && rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be_wr[b]) begin
                    mem[widx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_reg <= mem[widx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            load_ok_reg    <= 1'b0;
            f3_reg         <= 3'd0;
            lane_reg       <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        cnt_reg       <= 4'(LATENCY - 1);
                        req_ready_reg <= 1'b0;
                        load_ok_reg   <= access_ok & ~req_write;
                        f3_reg        <= req_func3;
                        lane_reg      <= req_addr[1:0];
                        if (LATENCY > 1) begin
                            state_reg <= WAIT;
                        end else begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    req_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    // Lane select and extension of the word captured at the accept edge.
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sign_en;
    logic [31:0] ext;

    assign sign_en = ~f3_reg[2];
    assign half_v  = lane_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];

    always_comb begin
        byte_v = rd_word_reg[7:0];
        case (lane_reg)
            2'd1:    byte_v = rd_word_reg[15:8];
            2'd2:    byte_v = rd_word_reg[23:16];
            2'd3:    byte_v = rd_word_reg[31:24];
            default: byte_v = rd_word_reg[7:0];
        endcase
    end

    always_comb begin
        ext = 32'd0;
        case (f3_reg[1:0])
            2'b00:   ext = {{24{sign_en & byte_v[7]}}, byte_v};
            2'b01:   ext = {{16{sign_en & half_v[15]}}, half_v};
            2'b10:   ext = rd_word_reg;
            default: ext = 32'd0;
        endcase
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = load_ok_reg ? ext : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, mid-transaction reset
// sequences, and randomized traffic against a byte-array reference model.
module tb_dmem_responder;
    localparam int LAT = 2;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_func3  (req_func3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: bytes of word indices 0..63, addressed by addr[7:0].
    logic [7:0] mb [256];

    task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rdata, output logic err);
        int  size;
        int  a;
        int  base;
        bit  undef;
        bit  mis;
        rdata = 32'd0;
        err   = 1'b0;
        a     = int'(addr[7:0]);
        undef = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis   = !undef && ((a % size) != 0);
        if (ERR_EN && (undef || mis)) begin
            err = 1'b1;
            return;
        end
        if (undef) return;
        base = a - (a % size);
        if (wr) begin
            for (int i = 0; i < size; i++) mb[base + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) rdata = rdata | (32'(mb[base + i]) << (8 * i));
            if (!f3[2] && size < 4 && mb[base + size - 1][7])
                rdata = rdata | (32'hFFFF_FFFF << (8 * size));
        end
    endtask

    // One full handshake; returns the response seen and checks latency, ready and hold stability.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input int hold,
                       output logic [31:0] rdata, output logic err);
        int n;
        bit rdy_bad;
        bit stable_bad;
        @(negedge clk);
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_func3  = f3;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_func3 = 3'($urandom);
        @(negedge clk);
        n = 0;
        rdy_bad = 1'b0;
        while (resp_valid !== 1'b1 && n < 40) begin
            if (req_ready !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(LAT - 1));
        rdata = resp_rdata;
        err   = resp_err;
        stable_bad = 1'b0;
        if (req_ready !== 1'b0) rdy_bad = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err) stable_bad = 1'b1;
            if (req_ready !== 1'b0) rdy_bad = 1'b1;
        end
        check("req_ready_low_busy", 32'(rdy_bad), 32'd0);
        check("resp_hold_stable", 32'(stable_bad), 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready_after_hs", 32'(req_ready), 32'd1);
        check("resp_valid_after_hs", 32'(resp_valid), 32'd0);
        $display("txn wr=%0d addr=%h wdata=%h f3=%0d hold=%0d rdata=%h err=%0d lat=%0d",
                 wr, addr, wdata, f3, hold, rdata, err, n + 1);
    endtask

    // Accept a request, then assert reset while the transaction is in WAIT.
    task automatic reset_mid(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_func3  = f3;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        check("rst_mid_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        $display("txn reset_mid wr=%0d addr=%h wdata=%h f3=%0d", wr, addr, wdata, f3);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vec [20];

    initial begin
        logic [31:0] r;
        logic        e;
        logic [31:0] mr;
        logic        me;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  f3;

        vec[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 0, 32'h0,        1'b0};
        vec[1]  = '{1'b0, 32'h10,   32'h0,        3'b010, 0, 32'hDEADBEEF, 1'b0};
        vec[2]  = '{1'b1, 32'h11,   32'h00000080, 3'b000, 1, 32'h0,        1'b0};
        vec[3]  = '{1'b0, 32'h11,   32'h0,        3'b000, 0, 32'hFFFFFF80, 1'b0};
        vec[4]  = '{1'b0, 32'h11,   32'h0,        3'b100, 0, 32'h00000080, 1'b0};
        vec[5]  = '{1'b0, 32'h10,   32'h0,        3'b010, 0, 32'hDEAD80EF, 1'b0};
        vec[6]  = '{1'b0, 32'h12,   32'h0,        3'b001, 0, 32'hFFFFDEAD, 1'b0};
        vec[7]  = '{1'b0, 32'h12,   32'h0,        3'b101, 2, 32'h0000DEAD, 1'b0};
        vec[8]  = '{1'b0, 32'h13,   32'h0,        3'b000, 0, 32'hFFFFFFDE, 1'b0};
        vec[9]  = '{1'b0, 32'h1010, 32'h0,        3'b010, 5, 32'hDEAD80EF, 1'b0};
        vec[10] = '{1'b0, 32'h12,   32'h0,        3'b010, 0, ERR_EN ? 32'h0 : 32'hDEAD80EF, ERR_EN};
        vec[11] = '{1'b0, 32'h10,   32'h0,        3'b010, 0, 32'hDEAD80EF, 1'b0};
        vec[12] = '{1'b0, 32'h10,   32'h0,        3'b011, 0, 32'h0,        ERR_EN};
        vec[13] = '{1'b1, 32'h10,   32'h12345678, 3'b011, 0, 32'h0,        ERR_EN};
        vec[14] = '{1'b1, 32'h10,   32'h12345678, 3'b111, 0, 32'h0,        ERR_EN};
        vec[15] = '{1'b0, 32'h10,   32'h0,        3'b010, 0, 32'hDEAD80EF, 1'b0};
        vec[16] = '{1'b1, 32'h14,   32'h11223344, 3'b010, 0, 32'h0,        1'b0};
        vec[17] = '{1'b1, 32'h16,   32'hABCD1234, 3'b001, 0, 32'h0,        1'b0};
        vec[18] = '{1'b0, 32'h14,   32'h0,        3'b010, 0, 32'h12343344, 1'b0};
        vec[19] = '{1'b0, 32'h16,   32'h0,        3'b001, 0, 32'h00001234, 1'b0};

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_func3  = 3'd0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        check("reset_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            txn(vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].f3, vec[i].hold, r, e);
            check($sformatf("vec%0d_rdata", i), r, vec[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vec[i].exp_err));
        end

        // Reset during a load's WAIT must not disturb the array.
        reset_mid(1'b0, 32'h10, 32'h0, 3'b010);
        txn(1'b0, 32'h10, 32'h0, 3'b010, 0, r, e);
        check("post_reset_lw", r, 32'hDEAD80EF);
        // A store accepted before reset stays committed.
        reset_mid(1'b1, 32'h18, 32'hCAFEF00D, 3'b010);
        txn(1'b0, 32'h18, 32'h0, 3'b010, 1, r, e);
        check("post_reset_store_kept", r, 32'hCAFEF00D);

        // Randomized traffic over word indices 0..63 with random wrap bits.
        for (int w = 0; w < 64; w++) begin
            addr = (32'($urandom) & 32'hFFFF_F000) | 32'(w * 4);
            txn(1'b1, addr, $urandom, 3'b010, 0, r, e);
            model(1'b1, addr, req_wdata, 3'b010, mr, me);
        end
        for (int w = 0; w < 64; w++) begin
            txn(1'b0, 32'(w * 4), 32'h0, 3'b010, 0, r, e);
            for (int b = 0; b < 4; b++) mb[w * 4 + b] = r[8*b +: 8];
        end
        for (int k = 0; k < 250; k++) begin
            logic [31:0] wd;
            wr   = 1'($urandom);
            addr = 32'($urandom) & 32'hFFFF_F0FF;
            f3   = 3'($urandom);
            wd   = $urandom;
            if (wr && (f3 == 3'd4 || f3 == 3'd5)) f3 = {1'b0, f3[1:0]};
            txn(wr, addr, wd, f3, $urandom_range(0, 3), r, e);
            model(wr, addr, wd, f3, mr, me);
            check("rand_rdata", r, mr);
            check("rand_err", 32'(e), 32'(me));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory load/store port; the target end of the request the datapath issues.
- Accepts one load/store request via valid/ready, performs the access on an internal word array, and returns load data (sign/zero-extended per funct3) or a store acknowledge after a fixed, parameterised latency.
- Replaces the zero-latency combinational data memory so the core can be exercised against a multi-cycle memory.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- LATENCY, 2, cycles from the accept edge to resp_valid rising (legal range 1..15).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for SB/SH.
- req_func3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  32  load result; 0 for stores.
- resp_err  out  1  error flag; see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Array contents are not reset.
- FSM states:
  - IDLE: req_ready=1. Accept on req_valid=1 at a rising edge. On accept, load counter=LATENCY-1; go to WAIT if LATENCY>1, otherwise go to RESP.
  - WAIT: req_ready=0. Decrement counter each cycle; at counter==1, the next edge moves to RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err are stable. Hold until resp_valid & resp_ready at an edge, then go to IDLE.
- req_ready=0 in WAIT and RESP. Only one transaction is outstanding; no back-to-back accept in the response cycle.
- Latency: resp_valid first seen high exactly LATENCY cycles after the accept edge.
- Array access happens at the accept edge:
  - Word index = req_addr[ADDR_W+1:2], with ADDR_W=log2(DEPTH_WORDS). Upper address bits are ignored (wrap modulo the array size).
  - Store SB: write the byte at lane addr[1:0] from wdata[7:0].
  - Store SH: write the half at lane addr[1] from wdata[15:0].
  - Store SW: write the full word. Use byte-enable writes; other bytes are untouched.
  - Load: select the byte/half lane by addr[1:0]. B and H sign-extend; BU and HU zero-extend; W returns the word.
  - The result is captured into a response register at the accept edge, so a later store cannot alter a pending response.
- Read-after-write: a load accepted after a store's response returns the newly stored data.
- Undefined funct3 (011, 110, 111): loads return 0; stores write nothing; the transaction still completes normally.
- Input signals outside an accept edge are don't-care.
- Reset mid-transaction: the response is discarded. A store accepted before reset remains committed.
- resp_ready held high while idle has no effect.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined:
  - Misaligned H/HU with addr[0]=1, or W with addr[1:0]!=0, performs no array access and returns resp_rdata=0, resp_err=1.
  - Undefined funct3 also sets resp_err=1.
  - Latency is unchanged.
- Undefined:
  - resp_err is tied 0.
  - Misaligned accesses are aligned down: H uses addr[1] only; W ignores addr[1:0].

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata=0xDEADBEEF; resp_valid rises exactly 2 cycles after each accept (LATENCY=2).
- After the SW above: SB addr 0x11 data 0x0000_0080, then LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080, LW 0x10 -> 0xDEAD80EF.
- LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD; LB 0x13 -> 0xFFFFFFDE.
- Backpressure: hold resp_ready=0 for 5 cycles during a LW -> resp_valid and resp_rdata held stable, req_ready=0 throughout; req_ready returns to 1 on the cycle after the handshake. With DEPTH_WORDS=1024, LW 0x1010 returns the word at 0x10 (wrap).
- Reset: drop rst low during WAIT of a LW -> resp_valid=0 and req_ready=1 immediately; a following LW returns the prior array contents (no corruption).
- With DMEM_MISALIGN_ERR_EN: LW 0x12 -> resp_err=1, rdata=0, array unchanged; funct3=011 -> resp_err=1. Without the macro: LW 0x12 returns the word at 0x10, resp_err=0.
